// File: rtl/aes_defs.sv
// rtl/aes_defs.sv - shared AES constants, state encodings, Rcon and S-box
package aes_defs;

  localparam int NUM_ROUNDS = 10;
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } key_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Round constant for rounds 1..10; other indices never used by the expander
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] rc;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_subword.sv
// rtl/aes_subword.sv - SubWord: S-box applied to each byte of a 32-bit word
module aes_subword
  import aes_defs::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  // Four copies of the shared S-box, one per byte lane
  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign word_out[8*i +: 8] = sbox(word_in[8*i +: 8]);
  end

endmodule

// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - iterative AES-128 key expansion, one round key per cycle
module aes_key_expand
  import aes_defs::*;
(
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         key_start,
  input  logic [127:0] key_in,
  output logic         key_busy,
  output logic         rkey_valid,
  output logic [3:0]   rkey_idx,
  output logic [127:0] rkey,
  output logic         key_done
);

  key_state_t   state, state_next;
  logic         load, advance;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic [3:0]   round_next;
  logic [31:0]  sub_out;
  logic [31:0]  temp, w0n, w1n, w2n, w3n;
  logic         valid_q, busy_q, done_q;

  assign round_next = round_idx + 4'd1;

  // Only one SubWord instance: the datapath reuses it every round
  aes_subword u_subword (
    .word_in  ({round_key[23:0], round_key[31:24]}),
    .word_out (sub_out)
  );

  // Derive the next round key from the current one
  always_comb begin
    temp = sub_out ^ {rcon(round_next), 24'h000000};
    w0n  = round_key[127:96] ^ temp;
    w1n  = round_key[95:64]  ^ w0n;
    w2n  = round_key[63:32]  ^ w1n;
    w3n  = round_key[31:0]   ^ w2n;
  end

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state and datapath control; starts are only honoured from IDLE
  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (key_start) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (round_idx >= LAST_ROUND) state_next = ST_IDLE;
        else                          advance    = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Round key register, saturating round counter and registered status flags
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      round_key <= '0;
      round_idx <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      valid_q <= load | advance;
      busy_q  <= load | advance;
      done_q  <= advance && (round_next == LAST_ROUND);
      if (load) begin
        round_key <= key_in;
        round_idx <= '0;
      end else if (advance) begin
        round_key <= {w0n, w1n, w2n, w3n};
        round_idx <= round_next;
      end
    end
  end

  assign rkey       = round_key;
  assign rkey_idx   = round_idx;
  assign rkey_valid = valid_q;
  assign key_busy   = busy_q;
  assign key_done   = done_q;

endmodule

// File: doc/aes_key_expand.md
AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset, with ports named as follows.
REQ-002 sys_clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 sys_rst  input  1  asynchronous active-high reset.
REQ-004 key_start  input  1  one-cycle request to expand key_in.
REQ-005 key_in  input  128  cipher key; bits [127:96] = w0 (column 1), [31:0] = w3; byte [31:24] of each word is row 0.
REQ-006 key_busy  output  1  high while an expansion is in progress.
REQ-007 rkey_valid  output  1  high in each cycle that rkey/rkey_idx carry a round key.
REQ-008 rkey_idx  output  4  round number 0..10 of the current rkey.
REQ-009 rkey  output  128  round key, with the same word and byte packing as key_in.
REQ-010 key_done  output  1  one-cycle pulse, coincident with round key 10.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-012 In IDLE, key_start=1 SHALL capture key_in and move to RUN; key_in is sampled only in that cycle.
REQ-013 For key_start at edge T, round key 0 (= key_in) SHALL appear at T+1 with rkey_valid=1 and rkey_idx=0.
REQ-014 Round key i SHALL appear at T+1+i for i=1..10, one per cycle, without gaps.
REQ-015 Round key i SHALL be computed from key i-1 as follows: temp = SubWord(RotWord(w3)) ^ Rcon[i], with RotWord(w) = {w[23:0], w[31:24]} and Rcon placed in bits [31:24].
REQ-016 The remaining words SHALL then be: w0' = w0 ^ temp, w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'.
REQ-017 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex).
REQ-018 key_done SHALL be 1 only in the cycle where rkey_idx=10 and rkey_valid=1.
REQ-019 The FSM SHALL return to IDLE on the edge after the round key 10 cycle.
REQ-020 key_busy SHALL be 1 from T+1 through T+11 inclusive, and 0 otherwise.
REQ-021 key_start SHALL be ignored while key_busy=1, including the key_done cycle; the earliest accepted restart is at edge T+12.
REQ-022 Outside valid cycles, rkey_valid SHALL be 0, rkey SHALL hold its last value, and rkey_idx SHALL hold its last value.
REQ-023 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-024 The round counter SHALL saturate at 10 and never wrap to 11..15.

Reset
REQ-025 sys_rst=1 SHALL immediately force: state=IDLE, key_busy=0, rkey_valid=0, key_done=0, rkey_idx=0, rkey=0, and the internal key register=0.
REQ-026 Reset asserted mid-expansion SHALL abort the expansion; no further round keys SHALL be emitted until a new key_start is accepted after reset release.
REQ-027 key_start SHALL be ignored while sys_rst=1.

Structure
REQ-028 The round count (10), the Rcon table and the state encodings SHALL reside in the shared AES definitions package/header aes_defs, for reuse by the encryption round controller.
REQ-029 SubWord SHALL be a sub-module, aes_subword: 32-bit in, 32-bit out, four instances of the same S-box table as the byte-substitution stage.
REQ-030 Exactly one aes_subword instance SHALL be used, giving an iterative datapath with one round per cycle.

Verification
REQ-031 Start with key_in = 2b7e151628aed2a6abf7158809cf4f3c: idx0 SHALL equal key_in, idx1 = a0fafe1788542cb123a339392a6c7605, idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with key_done=1 at T+11.
REQ-032 Start with key_in = 000102030405060708090a0b0c0d0e0f: idx10 SHALL equal 13111d7fe3944a17f307a78b4d2b30c5, and exactly 11 valid cycles SHALL occur.
REQ-033 Second key_start pulsed at T+5 and at T+11 with a different key: both SHALL be ignored, and the idx6..10 sequence SHALL be unchanged.
REQ-034 sys_rst asserted at T+6, released at T+8: outputs SHALL be zero/idle immediately, and no rkey_valid SHALL occur until a new start; a following start SHALL produce the correct full sequence.
REQ-035 Back-to-back: start at T, then start at T+12 with a new key: the second sequence SHALL begin at T+13 with idx0 equal to the new key, and key_busy SHALL be 0 only during cycle T+12.
